// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter:
// FSM state encoding, default payload width and the parity sense.
package uart_pkg;

   localparam int   DEFAULT_DATA_WIDTH = 8;
   localparam logic PARITY_ODD         = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DATA    = 3'd1,
      ST_PARITY  = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } uart_state_e;

   // A frame is good when the XOR of its data bits and parity bit matches the parity sense
   function automatic logic parity_fail(input logic data_xor, input logic par_bit);
      return ((data_xor ^ par_bit) != PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and enable in, payload, strobe and status out.
interface uart_rx_if import uart_pkg::*; #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic                  rx_en;
   logic                  rx_in;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  parity_err;
   logic                  frame_err;
   logic                  rx_busy;

   modport master (
      output rx_en, rx_in,
      input  rx_data, rx_valid, parity_err, frame_err, rx_busy
   );

   modport slave (
      input  rx_en, rx_in,
      output rx_data, rx_valid, parity_err, frame_err, rx_busy
   );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic uart_clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);
   logic [SYNC_STAGES-1:0] r_sync;

   // Shift the raw line through the synchronizer chain
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// UART receiver: one bit per uart_clk, start + LSB-first data + odd parity + stop,
// with a recovery state so a line stuck low after a bad stop is not taken as a new start.
module uart_rx import uart_pkg::*; #(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic     uart_clk,
   input  logic     rst_n,
   uart_rx_if.slave bus
);
   localparam int             CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);

   logic                  w_rx_s;
   uart_state_e           r_state;
   logic [CW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_parity;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic                  r_rx_valid;
   logic                  r_parity_err;
   logic                  r_frame_err;
   logic                  r_rx_busy;

   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .uart_clk (uart_clk),
      .rst_n    (rst_n),
      .i_async  (bus.rx_in),
      .o_sync   (w_rx_s)
   );

   // Frame FSM; rx_busy is registered alongside every state change so it always tracks state != IDLE
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_rx_busy    <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.rx_en && !w_rx_s) begin
                  r_state   <= ST_DATA;
                  r_bit_cnt <= '0;
                  r_rx_busy <= 1'b1;
               end else begin
                  r_state   <= ST_IDLE;
                  r_rx_busy <= 1'b0;
               end
            end
            ST_DATA: begin
               r_shift[r_bit_cnt] <= w_rx_s;
               if (r_bit_cnt == LAST_BIT) begin
                  r_state   <= ST_PARITY;
                  r_bit_cnt <= '0;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               r_parity <= w_rx_s;
               r_state  <= ST_STOP;
            end
            ST_STOP: begin
               r_rx_data    <= r_shift;
               r_parity_err <= parity_fail(^r_shift, r_parity);
               r_frame_err  <= ~w_rx_s;
               r_rx_valid   <= 1'b1;
               if (w_rx_s) begin
                  r_state   <= ST_IDLE;
                  r_rx_busy <= 1'b0;
               end else begin
                  r_state   <= ST_RECOVER;
                  r_rx_busy <= 1'b1;
               end
            end
            ST_RECOVER: begin
               if (w_rx_s) begin
                  r_state   <= ST_IDLE;
                  r_rx_busy <= 1'b0;
               end else begin
                  r_state   <= ST_RECOVER;
                  r_rx_busy <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_rx_busy <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data    = r_rx_data;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.parity_err = r_parity_err;
   assign bus.frame_err  = r_frame_err;
   assign bus.rx_busy    = r_rx_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, hand-written corner sequences
// and random frames scored against a frame-level reference model.
module tb_uart_rx;
   logic uart_clk = 1'b0;
   logic rst_n    = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   pcyc     = 0;

   uart_rx_if #(.DATA_WIDTH(8)) ifc ();

   uart_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .uart_clk (uart_clk),
      .rst_n    (rst_n),
      .bus      (ifc)
   );

   always #5 uart_clk = ~uart_clk;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       pe;
      logic       fe;
   } obs_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         hold_low;
      logic [7:0] exp_data;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   obs_t obs_q[$];
   obs_t exp_q[$];
   vec_t vecs[6];

   // Posedge counter used as the time base for latency checks
   always @(posedge uart_clk) pcyc <= pcyc + 1;

   // Record every rx_valid pulse, sampled away from the active edge
   always @(negedge uart_clk) begin
      if (ifc.rx_valid === 1'b1) begin
         obs_q.push_back('{pcyc, ifc.rx_data, ifc.parity_err, ifc.frame_err});
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge uart_clk);
         ifc.rx_in = 1'b1;
      end
   endtask

   // Drive one frame; drop_en_at >= 0 clears rx_en while that data bit is on the line
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int drop_en_at, output int start_cyc);
      @(negedge uart_clk);
      ifc.rx_in = 1'b0;
      start_cyc = pcyc;
      for (int i = 0; i < 8; i++) begin
         @(negedge uart_clk);
         ifc.rx_in = d[i];
         if (i == drop_en_at) ifc.rx_en = 1'b0;
      end
      @(negedge uart_clk);
      ifc.rx_in = par;
      @(negedge uart_clk);
      ifc.rx_in = stop;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"},  ifc.rx_data,    32'd0);
      check({tag, "_valid"}, ifc.rx_valid,   32'd0);
      check({tag, "_pe"},    ifc.parity_err, 32'd0);
      check({tag, "_fe"},    ifc.frame_err,  32'd0);
      check({tag, "_busy"},  ifc.rx_busy,    32'd0);
   endtask

   function automatic logic good_parity(input logic [7:0] d);
      return (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
   endfunction

   initial begin
      int st;
      int st2;
      ifc.rx_en = 1'b1;
      ifc.rx_in = 1'b1;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b1, 1'b0, 3, 8'h3C, 1'b0, 1'b1};
      vecs[3] = '{8'h5A, 1'b1, 1'b1, 0, 8'h5A, 1'b0, 1'b0};
      vecs[4] = '{8'h01, 1'b1, 1'b1, 0, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{8'h7F, 1'b0, 1'b0, 0, 8'h7F, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(posedge uart_clk);
      #1;
      check_outputs_zero("reset");
      @(negedge uart_clk);
      rst_n = 1'b1;
      idle(3);

      // Directed vector table
      foreach (vecs[v]) begin
         obs_q.delete();
         send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, -1, st);
         if (vecs[v].hold_low > 0) begin
            repeat (vecs[v].hold_low) begin
               @(negedge uart_clk);
               ifc.rx_in = 1'b0;
            end
            idle(1);
            @(negedge uart_clk);
            check($sformatf("vec%0d_busy_recover", v), ifc.rx_busy, 32'd1);
         end
         idle(5);
         check($sformatf("vec%0d_count", v), obs_q.size(), 32'd1);
         if (obs_q.size() >= 1) begin
            check($sformatf("vec%0d_latency", v), obs_q[0].cyc - st, 32'd13);
            check($sformatf("vec%0d_data", v), obs_q[0].data, vecs[v].exp_data);
            check($sformatf("vec%0d_pe", v), obs_q[0].pe, vecs[v].exp_pe);
            check($sformatf("vec%0d_fe", v), obs_q[0].fe, vecs[v].exp_fe);
         end
         check($sformatf("vec%0d_busy_after", v), ifc.rx_busy, 32'd0);
      end

      // Back-to-back frames with no idle gap
      obs_q.delete();
      send_frame(8'h00, 1'b1, 1'b1, -1, st);
      send_frame(8'hFF, 1'b1, 1'b1, -1, st2);
      idle(5);
      check("b2b_count", obs_q.size(), 32'd2);
      if (obs_q.size() == 2) begin
         check("b2b_gap", obs_q[1].cyc - obs_q[0].cyc, 32'd11);
         check("b2b_data0", obs_q[0].data, 32'h00);
         check("b2b_data1", obs_q[1].data, 32'hFF);
         check("b2b_err0", {obs_q[0].pe, obs_q[0].fe}, 32'd0);
         check("b2b_err1", {obs_q[1].pe, obs_q[1].fe}, 32'd0);
      end

      // Reset pulsed after the fourth data bit
      obs_q.delete();
      @(negedge uart_clk);
      ifc.rx_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge uart_clk);
         ifc.rx_in = i[0];
      end
      @(negedge uart_clk);
      rst_n = 1'b0;
      ifc.rx_in = 1'b1;
      @(posedge uart_clk);
      #1;
      check_outputs_zero("midrst");
      @(negedge uart_clk);
      rst_n = 1'b1;
      idle(14);
      check("midrst_no_valid", obs_q.size(), 32'd0);
      send_frame(8'h5A, 1'b1, 1'b1, -1, st);
      idle(5);
      check("midrst_count", obs_q.size(), 32'd1);
      if (obs_q.size() >= 1) check("midrst_data", obs_q[0].data, 32'h5A);

      // rx_en low for a whole frame, then dropped mid-frame of the next
      obs_q.delete();
      ifc.rx_en = 1'b0;
      send_frame(8'h81, 1'b1, 1'b1, -1, st);
      idle(5);
      check("en_off_ignored", obs_q.size(), 32'd0);
      ifc.rx_en = 1'b1;
      idle(2);
      send_frame(8'hC3, 1'b1, 1'b1, 3, st);
      idle(5);
      check("en_drop_count", obs_q.size(), 32'd1);
      if (obs_q.size() >= 1) begin
         check("en_drop_data", obs_q[0].data, 32'hC3);
         check("en_drop_err", {obs_q[0].pe, obs_q[0].fe}, 32'd0);
      end
      ifc.rx_en = 1'b1;
      idle(3);

      // Random frames against the frame-level model
      obs_q.delete();
      exp_q.delete();
      for (int k = 0; k < 40; k++) begin
         logic [7:0] d;
         logic       par;
         logic       bad_stop;
         d        = 8'($urandom);
         par      = good_parity(d) ^ ($urandom_range(0, 3) == 0);
         bad_stop = ($urandom_range(0, 6) == 0);
         send_frame(d, par, ~bad_stop, -1, st);
         exp_q.push_back('{st + 13, d, ($countones({d, par}) % 2) == 0, bad_stop});
         idle(bad_stop ? $urandom_range(1, 3) : $urandom_range(0, 3));
      end
      idle(6);
      check("rand_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("rand%0d_cyc", i), obs_q[i].cyc, exp_q[i].cyc);
         check($sformatf("rand%0d_data", i), obs_q[i].data, exp_q[i].data);
         check($sformatf("rand%0d_pe", i), obs_q[i].pe, exp_q[i].pe);
         check($sformatf("rand%0d_fe", i), obs_q[i].fe, exp_q[i].fe);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
